seq_multiplier: RTL and testbench

Multi-cycle radix-2 shift-add multiplier, the multiplication counterpart of the combinational divider in the execute stage. It covers the RV32M multiply ops MUL, MULH, MULHSU and MULHU. Pipeline control stalls on busy_o and captures result_o on the valid_o pulse. It trades latency (WIDTH cycles) for a single adder, which keeps the critical path short.

---
 rtl/seq_multiplier.sv | 127 ++++++++++++
 tb/tb_seq_multiplier.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// One add per cycle on operand magnitudes; the sign is applied once on completion.
module seq_multiplier #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [1:0]           op_i,
    input  logic [WIDTH-1:0]     multiplicand_i,
    input  logic [WIDTH-1:0]     multiplier_i,
    output logic                 busy_o,
    output logic                 valid_o,
    output logic [WIDTH-1:0]     result_o,
    output logic [2*WIDTH-1:0]   product_o
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                state;
    state_t                state_next;
    logic [CW-1:0]         count;
    logic [1:0]            op;
    logic                  neg;
    logic [WIDTH-1:0]      mcand;
    logic [WIDTH-1:0]      mplier;
    logic [2*WIDTH:0]      acc;

    logic                  a_neg;
    logic                  b_neg;
    logic [WIDTH-1:0]      a_mag;
    logic [WIDTH-1:0]      b_mag;
    logic [WIDTH:0]        upper_sum;
    logic [2*WIDTH:0]      acc_step;
    logic [2*WIDTH-1:0]    final_prod;

    // Magnitudes: negating the most negative value wraps to 2^(WIDTH-1), which is
    // exactly the unsigned magnitude we want.
    always_comb begin
        a_neg = ((op_i == OP_MULH) || (op_i == OP_MULHSU)) && multiplicand_i[WIDTH-1];
        b_neg = (op_i == OP_MULH) && multiplier_i[WIDTH-1];
        a_mag = a_neg ? -multiplicand_i : multiplicand_i;
        b_mag = b_neg ? -multiplier_i : multiplier_i;
    end

    always_comb begin
        upper_sum  = mplier[0] ? ({1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand})
                               : acc[2*WIDTH:WIDTH];
        acc_step   = {upper_sum, acc[WIDTH-1:0]} >> 1;
        final_prod = neg ? -acc_step[2*WIDTH-1:0] : acc_step[2*WIDTH-1:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy_o     = 1'b0;
        valid_o    = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                busy_o = 1'b1;
                if (count == CW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                valid_o    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count     <= '0;
            op        <= '0;
            neg       <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            result_o  <= '0;
            product_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        op     <= op_i;
                        neg    <= a_neg ^ b_neg;
                        mcand  <= a_mag;
                        mplier <= b_mag;
                        acc    <= '0;
                        count  <= CW'(WIDTH);
                    end
                end
                CALC: begin
                    acc    <= acc_step;
                    mplier <= mplier >> 1;
                    count  <= count - 1'b1;
                    if (count == CW'(1)) begin
                        product_o <= final_prod;
                        result_o  <= (op == OP_MUL) ? final_prod[WIDTH-1:0]
                                                    : final_prod[2*WIDTH-1:WIDTH];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: directed ops push expected results and
// completion cycles; a forked monitor checks every valid_o pulse against them.
module tb_seq_multiplier;

    localparam int unsigned WIDTH = 32;

    typedef struct {
        logic [WIDTH-1:0]   res;
        logic [2*WIDTH-1:0] prod;
        int unsigned        cyc;
        string              name;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic [1:0]           op = 2'b00;
    logic [WIDTH-1:0]     a = '0;
    logic [WIDTH-1:0]     b = '0;
    logic                 busy;
    logic                 valid;
    logic [WIDTH-1:0]     result;
    logic [2*WIDTH-1:0]   product;

    int unsigned cyc = 0;
    int unsigned passed = 0;
    int unsigned total = 0;
    exp_t        sb[$];

    seq_multiplier #(.WIDTH(WIDTH)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .op_i           (op),
        .multiplicand_i (a),
        .multiplier_i   (b),
        .busy_o         (busy),
        .valid_o        (valid),
        .result_o       (result),
        .product_o      (product)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 128'(valid), 128'(0));
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_result"}, 128'(result), 128'(e.res));
                    chk({e.name, "_product"}, 128'(product), 128'(e.prod));
                    chk({e.name, "_latency"}, 128'(cyc), 128'(e.cyc));
                    chk({e.name, "_busy_low"}, 128'(busy), 128'(0));
                end
            end
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the accepting edge.
    task automatic issue(input string name, input logic [1:0] o, input logic [WIDTH-1:0] x,
                         input logic [WIDTH-1:0] y, input logic [WIDTH-1:0] er,
                         input logic [2*WIDTH-1:0] ep, input bit expect_done);
        exp_t e;
        start = 1'b1; op = o; a = x; b = y;
        if (expect_done) begin
            e.res = er; e.prod = ep; e.cyc = cyc + 1 + WIDTH; e.name = name;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        a = '0; b = '0;
    endtask

    task automatic drain(input string name);
        int unsigned n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drain_pending"}, 128'(sb.size()), 128'(0));
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bit seen;
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_valid", 128'(valid), 128'(0));
        chk("rst_result", 128'(result), 128'(0));
        chk("rst_product", 128'(product), 128'(0));
        rst = 1'b0;
        @(negedge clk);

        // 1: MUL 7*6, busy every cycle of CALC
        issue("mul_7x6", 2'b00, 32'd7, 32'd6, 32'h0000002A, 64'h2A, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (busy !== 1'b1 || valid !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        chk("mul_7x6_busy_during_calc", 128'(seen), 128'(0));
        drain("mul_7x6");

        // 2/3: signedness corners
        issue("mulhu_ff", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 64'hFFFFFFFE_00000001, 1'b1);
        drain("mulhu_ff");
        issue("mulh_ff", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 64'h1, 1'b1);
        drain("mulh_ff");
        issue("mulhsu_ff", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFF_00000001, 1'b1);
        drain("mulhsu_ff");
        issue("mulh_min", 2'b01, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 64'h00000000_80000000, 1'b1);
        drain("mulh_min");
        issue("mul_neg1x2", 2'b00, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE, 64'h1_FFFFFFFE, 1'b1);
        drain("mul_neg1x2");
        issue("mul_zero", 2'b00, 32'h0, 32'h12345678, 32'h0, 64'h0, 1'b1);
        drain("mul_zero");

        // 4: start during CALC is ignored; result holds afterwards
        issue("mul_3x5", 2'b00, 32'd3, 32'd5, 32'd15, 64'd15, 1'b1);
        repeat (9) @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        drain("mul_3x5");
        repeat (5) @(negedge clk);
        chk("mul_3x5_hold_result", 128'(result), 128'(15));
        chk("mul_3x5_hold_product", 128'(product), 128'(15));

        // 5: async reset mid-CALC aborts
        issue("mulhu_abort", 2'b11, 32'h12345678, 32'h9ABCDEF0, '0, '0, 1'b0);
        repeat (15) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_valid", 128'(valid), 128'(0));
        chk("abort_result", 128'(result), 128'(0));
        chk("abort_product", 128'(product), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid) seen = 1'b1;
        end
        chk("abort_no_valid", 128'(seen), 128'(0));
        issue("mul_2x2", 2'b00, 32'd2, 32'd2, 32'd4, 64'd4, 1'b1);
        drain("mul_2x2");

        // 6: start held high -> accepts at k*(WIDTH+2)
        start = 1'b1; op = 2'b00; a = 32'd1; b = 32'd1;
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            e.res = 32'd1; e.prod = 64'd1; e.name = "mul_1x1_held";
            e.cyc = cyc + 1 + WIDTH + k * (WIDTH + 2);
            sb.push_back(e);
        end
        repeat (100) @(negedge clk);
        start = 1'b0;
        drain("mul_1x1_held");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
